// File: rtl/addr_presence_tracker.sv
// Small associative table of {addr, data} entries with one-cycle lookup.
// Commands are write/delete/clear; the clear sweeps one entry per cycle.
module addr_presence_tracker #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [AW-1:0]              cmd_addr,
  input  logic [DW-1:0]              cmd_data,
  input  logic                       lk_valid,
  input  logic [AW-1:0]              lk_addr,
  output logic                       lk_resp_valid,
  output logic                       lk_exists,
  output logic [DW-1:0]              lk_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_DEL = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [0:0]       state;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [IW-1:0]    clr_idx;

  logic          cmd_hit;
  logic [IW-1:0] cmd_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          lk_hit;
  logic [DW-1:0] lk_sel;

  always_comb begin
    cmd_hit    = 1'b0;
    cmd_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    lk_hit     = 1'b0;
    lk_sel     = '0;
    // Descending scan so the lowest free index wins.
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (valid[i] && addr_q[i] == cmd_addr) begin
        cmd_hit = 1'b1;
        cmd_idx = IW'(i);
      end
      if (valid[i] && addr_q[i] == lk_addr) begin
        lk_hit = 1'b1;
        lk_sel = data_q[i];
      end
    end
  end

  logic accept;
  logic do_wr;
  logic wr_upd;
  logic wr_new;
  logic wr_drop;
  logic do_del;
  logic do_clr;
  logic do_rsv;
  logic clr_dec;
  logic clr_last;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign do_wr     = accept && cmd_op == OP_WR;
  assign wr_upd    = do_wr && cmd_hit;
  assign wr_new    = do_wr && !cmd_hit && free_found;
  assign wr_drop   = do_wr && !cmd_hit && !free_found;
  assign do_del    = accept && cmd_op == OP_DEL && cmd_hit;
  assign do_clr    = accept && cmd_op == OP_CLR;
  assign do_rsv    = accept && cmd_op == OP_RSV;
  assign clr_dec   = (state == CLEAR) && valid[clr_idx];
  assign clr_last  = clr_idx == IW'(DEPTH-1);

  logic [CW-1:0] next_count;

  always_comb begin
    next_count = count;
    unique case (1'b1)
      wr_new:            next_count = count + CW'(1);
      do_del || clr_dec: next_count = count - CW'(1);
      default:           next_count = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      clr_idx <= '0;
      count   <= '0;
      full    <= 1'b0;
      err     <= 1'b0;
    end else begin
      count <= next_count;
      full  <= next_count == CW'(DEPTH);
      err   <= wr_drop || do_rsv;
      if (wr_new) valid[free_idx] <= 1'b1;
      if (do_del) valid[cmd_idx] <= 1'b0;
      if (state == CLEAR) begin
        valid[clr_idx] <= 1'b0;
        clr_idx        <= clr_idx + IW'(1);
        if (clr_last) state <= IDLE;
      end else if (do_clr) begin
        state   <= CLEAR;
        clr_idx <= '0;
      end
    end
  end

  // Payload storage carries no reset; only valid bits gate visibility.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_upd) data_q[cmd_idx] <= cmd_data;
      if (wr_new) begin
        addr_q[free_idx] <= cmd_addr;
        data_q[free_idx] <= cmd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_resp_valid <= 1'b0;
      lk_exists     <= 1'b0;
      lk_data       <= '0;
    end else begin
      lk_resp_valid <= lk_valid;
      lk_exists     <= lk_valid && lk_hit && state == IDLE;
      lk_data       <= (lk_valid && lk_hit && state == IDLE) ? lk_sel : '0;
    end
  end

endmodule

// File: tb/tb_addr_presence_tracker.sv
// Directed bench for addr_presence_tracker.
// Table of single-cycle vectors plus fill, clear and reset-mid-clear sequences.
module tb_addr_presence_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        lk_resp_valid;
  logic        lk_exists;
  logic [31:0] lk_data;
  logic [3:0]  count;
  logic        full;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_presence_tracker #(.DEPTH(8), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .lk_valid(lk_valid), .lk_addr(lk_addr),
    .lk_resp_valid(lk_resp_valid), .lk_exists(lk_exists),
    .lk_data(lk_data), .count(count), .full(full), .err(err)
  );

  typedef struct {
    bit          cv;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    bit          lv;
    logic [31:0] la;
    bit          e_resp;
    bit          e_ex;
    logic [31:0] e_data;
    logic [3:0]  e_cnt;
    bit          e_full;
    bit          e_err;
  } vec_t;

  vec_t tv[13];

  function automatic vec_t mk(bit cv, logic [1:0] op,
                              logic [31:0] a, logic [31:0] d,
                              bit lv, logic [31:0] la,
                              bit er, bit ee, logic [31:0] ed,
                              logic [3:0] ec, bit ef, bit eerr);
    vec_t v;
    v.cv = cv; v.op = op; v.a = a; v.d = d;
    v.lv = lv; v.la = la;
    v.e_resp = er; v.e_ex = ee; v.e_data = ed;
    v.e_cnt = ec; v.e_full = ef; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(bit cv, logic [1:0] op,
                     logic [31:0] a, logic [31:0] d,
                     bit lv, logic [31:0] la);
    cmd_valid = cv; cmd_op = op; cmd_addr = a; cmd_data = d;
    lk_valid = lv; lk_addr = la;
    step();
    cmd_valid = 1'b0;
    lk_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b00, 32'h100 + i, 32'hD0 + i, 0, 0);
      chk($sformatf("fill_count_%0d", i), 32'(count), i + 1);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0;
    lk_valid = 0; lk_addr = 0;

    tv[0]  = mk(1, 2'b00, 32'h10, 32'hAA, 0, 0,
                0, 0, 0, 1, 0, 0);
    tv[1]  = mk(0, 2'b00, 0, 0, 1, 32'h10,
                1, 1, 32'hAA, 1, 0, 0);
    tv[2]  = mk(1, 2'b00, 32'h20, 32'h55, 1, 32'h20,
                1, 0, 0, 2, 0, 0);
    tv[3]  = mk(0, 2'b00, 0, 0, 1, 32'h20,
                1, 1, 32'h55, 2, 0, 0);
    tv[4]  = mk(1, 2'b00, 32'h30, 32'h1, 0, 0,
                0, 0, 0, 3, 0, 0);
    tv[5]  = mk(1, 2'b00, 32'h30, 32'h2, 0, 0,
                0, 0, 0, 3, 0, 0);
    tv[6]  = mk(1, 2'b01, 32'h44, 0, 0, 0,
                0, 0, 0, 3, 0, 0);
    tv[7]  = mk(0, 2'b00, 0, 0, 1, 32'h30,
                1, 1, 32'h2, 3, 0, 0);
    tv[8]  = mk(1, 2'b11, 32'h10, 32'h0, 0, 0,
                0, 0, 0, 3, 0, 1);
    tv[9]  = mk(0, 2'b00, 0, 0, 0, 0,
                0, 0, 0, 3, 0, 0);
    tv[10] = mk(1, 2'b01, 32'h10, 0, 1, 32'h10,
                1, 1, 32'hAA, 2, 0, 0);
    tv[11] = mk(0, 2'b00, 0, 0, 1, 32'h10,
                1, 0, 0, 2, 0, 0);
    tv[12] = mk(0, 2'b00, 0, 0, 1, 32'h8000_0020,
                1, 0, 0, 2, 0, 0);

    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_resp", 32'(lk_resp_valid), 0);
    chk("rst_exists", 32'(lk_exists), 0);
    chk("rst_data", lk_data, 0);
    chk("rst_ready", 32'(cmd_ready), 1);

    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].cv, tv[i].op, tv[i].a, tv[i].d, tv[i].lv, tv[i].la);
      chk($sformatf("v%0d_resp", i), 32'(lk_resp_valid), 32'(tv[i].e_resp));
      chk($sformatf("v%0d_exists", i), 32'(lk_exists), 32'(tv[i].e_ex));
      chk($sformatf("v%0d_data", i), lk_data, tv[i].e_data);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].e_cnt));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].e_full));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].e_err));
      chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 1);
    end

    // Fill, then a write to a new address overflows.
    do_reset();
    fill8();
    chk("fill_full", 32'(full), 1);
    cyc(1, 2'b00, 32'h99, 32'hEE, 0, 0);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_count", 32'(count), 8);
    cyc(0, 2'b00, 0, 0, 1, 32'h99);
    chk("ovf_err_once", 32'(err), 0);
    chk("ovf_lk_99", 32'(lk_exists), 0);
    chk("ovf_full", 32'(full), 1);
    cyc(1, 2'b00, 32'h103, 32'h77, 1, 32'h105);
    chk("full_upd_err", 32'(err), 0);
    chk("full_lk_105", lk_data, 32'hD5);
    cyc(0, 2'b00, 0, 0, 1, 32'h103);
    chk("full_upd_data", lk_data, 32'h77);
    cyc(1, 2'b01, 32'h102, 0, 0, 0);
    chk("del_count", 32'(count), 7);
    chk("del_full", 32'(full), 0);
    cyc(1, 2'b00, 32'h99, 32'hEE, 0, 0);
    chk("refill_count", 32'(count), 8);
    chk("refill_err", 32'(err), 0);
    cyc(0, 2'b00, 0, 0, 1, 32'h99);
    chk("refill_lk", lk_data, 32'hEE);

    // Clear sweep with lookups each cycle.
    cyc(1, 2'b10, 0, 0, 0, 0);
    chk("clr_acc_count", 32'(count), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("clr_ready_%0d", k), 32'(cmd_ready), 0);
      cyc(1, 2'b00, 32'h200, 32'h1, 1, 32'h105);
      chk($sformatf("clr_count_%0d", k), 32'(count), 7 - k);
      chk($sformatf("clr_resp_%0d", k), 32'(lk_resp_valid), 1);
      chk($sformatf("clr_ex_%0d", k), 32'(lk_exists), 0);
      chk($sformatf("clr_data_%0d", k), lk_data, 0);
    end
    chk("clr_ready_after", 32'(cmd_ready), 1);
    chk("clr_full_after", 32'(full), 0);
    cyc(0, 2'b00, 0, 0, 1, 32'h200);
    chk("clr_blocked_wr", 32'(lk_exists), 0);

    // Reset in the third CLEAR cycle, with a competing write.
    fill8();
    cyc(1, 2'b10, 0, 0, 0, 0);
    step();
    step();
    chk("mid_clr_count", 32'(count), 6);
    rst = 1'b1;
    cyc(1, 2'b00, 32'h300, 32'h3, 1, 32'h107);
    rst = 1'b0;
    chk("rstclr_count", 32'(count), 0);
    chk("rstclr_ready", 32'(cmd_ready), 1);
    chk("rstclr_full", 32'(full), 0);
    chk("rstclr_err", 32'(err), 0);
    chk("rstclr_resp", 32'(lk_resp_valid), 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 2'b00, 0, 0, 1, (i == 8) ? 32'h300 : 32'h100 + i);
      chk($sformatf("rstclr_lk_%0d", i), 32'(lk_exists), 0);
    end
    chk("rstclr_count_end", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_presence_tracker.md
ADDR_PRESENCE_TRACKER -- requirements
Module: addr_presence_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of tracked entries (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_op  input  2  00 write, 01 delete, 10 clear, 11 reserved.
REQ-009 SHALL have port cmd_addr  input  AW  command address.
REQ-010 SHALL have port cmd_data  input  DW  write data.
REQ-011 SHALL have port lk_valid  input  1  lookup request; no backpressure.
REQ-012 SHALL have port lk_addr  input  AW  lookup address.
REQ-013 SHALL have port lk_resp_valid  output  1  lookup response strobe.
REQ-014 SHALL have port lk_exists  output  1  address present at lookup time.
REQ-015 SHALL have port lk_data  output  DW  stored data when lk_exists, else 0.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-017 SHALL have port full  output  1  count == DEPTH.
REQ-018 SHALL have port err  output  1  one-cycle error pulse.

Function
REQ-019 SHALL store up to DEPTH {valid, addr, data} entries; addresses unique among valid entries.
REQ-020 SHALL run a two-state FSM: IDLE (cmd_ready=1) and CLEAR (cmd_ready=0).
REQ-021 Write, address present: data overwritten at the accept edge; count unchanged; no err.
REQ-022 Write, address absent, not full: lowest-index invalid entry allocated at the accept edge; count +1.
REQ-023 Write, address absent, full: command dropped, table unchanged, err=1 the following cycle.
REQ-024 Delete, address present: entry valid cleared at the accept edge; count -1.
REQ-025 Delete, address absent: no-op, no err.
REQ-026 Clear: IDLE->CLEAR on accept; in CLEAR, entry i invalidated in the i-th cycle for i=0..DEPTH-1; return to IDLE after entry DEPTH-1 is cleared; DEPTH cycles total in CLEAR.
REQ-027 Reserved op (11): accepted, table unchanged, err=1 the following cycle.
REQ-028 Lookup latency SHALL be exactly 1 cycle: lk_resp_valid=1 in the cycle after lk_valid=1, else 0.
REQ-029 Lookup SHALL see table state before any update at the same edge; write and lookup to the same address in one cycle return pre-write state.
REQ-030 Lookup in the same cycle as a write accepted in the previous cycle SHALL see the written entry.
REQ-031 Lookups presented while in CLEAR SHALL return lk_exists=0, lk_data=0.
REQ-032 count and full SHALL be registered and SHALL reflect the table after each edge; count is updated per entry during CLEAR.
REQ-033 Address match SHALL compare all AW bits; no partial or wildcard match.

Reset
REQ-034 rst=1 SHALL invalidate all entries and force FSM=IDLE, count=0, full=0, err=0, lk_resp_valid=0, lk_exists=0, lk_data=0; cmd_ready=1 from the first cycle after reset.
REQ-035 rst asserted mid-CLEAR SHALL abort the sweep and apply REQ-034; rst SHALL take priority over any same-cycle command or lookup.
REQ-036 Entry addr/data contents need not be reset; only valid bits and outputs are.

Verification
REQ-037 Write 0x10/0xAA, next cycle lookup 0x10 -> lk_exists=1, lk_data=0xAA, count=1.
REQ-038 Write 0x20/0x55 and lookup 0x20 in the same cycle -> lk_exists=0; lookup one cycle later -> lk_exists=1, lk_data=0x55.
REQ-039 Fill with 8 distinct addresses, then write new 0x99 -> full=1, err pulses once, count=8, lookup 0x99 -> lk_exists=0.
REQ-040 Write 0x30/0x1 then 0x30/0x2, delete 0x44 -> count=1, lookup 0x30 returns 0x2, err never asserted.
REQ-041 Fill 8 entries, issue clear -> cmd_ready=0 for 8 cycles, count steps 7..0, lookups during sweep return 0, cmd_ready=1 afterwards.
REQ-042 Assert rst in the 3rd cycle of CLEAR -> next cycle count=0, cmd_ready=1, all lookups return lk_exists=0.
